agc_overload_det: RTL

- Upstream stage of the AGC loop. Consumes the digitised amplified_signal sample stream and produces the overload flag that the agc gain-search FSM sequences on.
- Measures sample magnitude over a fixed window of valid samples and reports a per-window overload decision plus the window peak.
- After every gain update from the agc (gain_changed), discards a settle interval before measuring again.

---
 rtl/agc_pkg.sv | 24 ++
 rtl/agc_overload_det_if.sv | 38 +++
 rtl/agc_peak_tracker.sv | 59 +++++
 rtl/agc_overload_det.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared AGC types and helpers: FSM state encoding, counter sizing
// and the sample magnitude function reused by future RSSI logic.
package agc_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_MEASURE,
        ST_REPORT
    } agc_state_e;

    localparam int MAG_W = 32;

    // Bits needed to hold 0..n inclusive, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic logic [MAG_W-1:0] mag_abs(
        input logic signed [MAG_W-1:0] s
    );
        return s[MAG_W-1] ? MAG_W'(-s) : MAG_W'(s);
    endfunction

endpackage

// File: rtl/agc_overload_det_if.sv
// Sample stream in, overload decision out, between the ADC/VGA chain,
// the agc gain-search FSM and the overload detector.
interface agc_overload_det_if #(
    parameter int DATA_W = 16
);

    logic signed [DATA_W-1:0] amplified_signal;
    logic                     sample_valid;
    logic                     gain_changed;
    logic        [DATA_W-1:0] threshold;
    logic                     overload;
    logic                     overload_valid;
    logic        [DATA_W-1:0] peak_out;
    logic                     busy;

    modport master (
        output amplified_signal,
        output sample_valid,
        output gain_changed,
        output threshold,
        input  overload,
        input  overload_valid,
        input  peak_out,
        input  busy
    );

    modport slave (
        input  amplified_signal,
        input  sample_valid,
        input  gain_changed,
        input  threshold,
        output overload,
        output overload_valid,
        output peak_out,
        output busy
    );

endinterface

// File: rtl/agc_peak_tracker.sv
// Per-window magnitude peak and saturating threshold-hit accumulator.
module agc_peak_tracker
    import agc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MIN_HITS = 2,
    parameter int HW       = cnt_w(MIN_HITS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic        [DATA_W-1:0] thr,
    output logic        [DATA_W-1:0] peak,
    output logic        [HW-1:0]     hits
);

    localparam logic [HW-1:0] HIT_MAX = HW'(MIN_HITS);

    logic [DATA_W-1:0] mag;
    logic              hit;
    logic [DATA_W-1:0] peak_d, peak_q;
    logic [HW-1:0]     hits_d, hits_q;

    // The most negative sample maps to 2^(DATA_W-1), still DATA_W bits.
    assign mag = DATA_W'(mag_abs(MAG_W'(sample)));
    assign hit = (mag >= thr);

    always_comb begin
        peak_d = peak_q;
        hits_d = hits_q;
        if (clr) begin
            peak_d = '0;
            hits_d = '0;
        end else if (en) begin
            if (mag > peak_q) begin
                peak_d = mag;
            end
            if (hit && (hits_q != HIT_MAX)) begin
                hits_d = hits_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
            hits_q <= '0;
        end else begin
            peak_q <= peak_d;
            hits_q <= hits_d;
        end
    end

    assign peak = peak_q;
    assign hits = hits_q;

endmodule

// File: rtl/agc_overload_det.sv
// AGC overload detector: settle after each gain change, then report
// per-window overload and peak magnitude to the agc gain-search FSM.
module agc_overload_det
    import agc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int WINDOW   = 64,
    parameter int SETTLE   = 16,
    parameter int MIN_HITS = 2
) (
    input  logic                clk,
    input  logic                RESETn,
    agc_overload_det_if.slave   bus
);

    localparam int CW = cnt_w(WINDOW);
    localparam int SW = cnt_w(SETTLE);
    localparam int HW = cnt_w(MIN_HITS);

    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
    localparam logic [SW-1:0] SET_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [HW-1:0] HIT_MAX  = HW'(MIN_HITS);

    agc_state_e        state_d, state_q;
    logic [CW-1:0]     sample_cnt_d, sample_cnt_q;
    logic [SW-1:0]     settle_cnt_d, settle_cnt_q;
    logic [DATA_W-1:0] thr_d, thr_q;
    logic              overload_d, overload_q;
    logic              ov_valid_d, ov_valid_q;
    logic [DATA_W-1:0] peak_out_d, peak_out_q;

    logic              trk_clr;
    logic              trk_en;
    logic              start;
    logic [DATA_W-1:0] trk_peak;
    logic [HW-1:0]     trk_hits;

    agc_peak_tracker #(
        .DATA_W   (DATA_W),
        .MIN_HITS (MIN_HITS),
        .HW       (HW)
    ) u_trk (
        .clk    (clk),
        .rst_n  (RESETn),
        .clr    (trk_clr),
        .en     (trk_en),
        .sample (bus.amplified_signal),
        .thr    (thr_q),
        .peak   (trk_peak),
        .hits   (trk_hits)
    );

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        settle_cnt_d = settle_cnt_q;
        thr_d        = thr_q;
        overload_d   = overload_q;
        ov_valid_d   = 1'b0;
        peak_out_d   = peak_out_q;
        trk_clr      = 1'b0;
        trk_en       = 1'b0;
        start        = 1'b0;

        // A gain change aborts whatever is in flight, including a report.
        if (bus.gain_changed) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            sample_cnt_d = '0;
            trk_clr      = 1'b1;
        end else begin
            unique case (state_q)
                ST_SETTLE: begin
                    if (SETTLE == 0) begin
                        start = 1'b1;
                    end else if (bus.sample_valid) begin
                        if (settle_cnt_q == SET_LAST) begin
                            start = 1'b1;
                        end else begin
                            settle_cnt_d = settle_cnt_q + SW'(1);
                        end
                    end
                end
                ST_MEASURE: begin
                    if (bus.sample_valid) begin
                        trk_en = 1'b1;
                        if (sample_cnt_q == WIN_LAST) begin
                            state_d      = ST_REPORT;
                            sample_cnt_d = '0;
                        end else begin
                            sample_cnt_d = sample_cnt_q + CW'(1);
                        end
                    end
                end
                ST_REPORT: begin
                    overload_d = (trk_hits == HIT_MAX);
                    peak_out_d = trk_peak;
                    ov_valid_d = 1'b1;
                    start      = 1'b1;
                end
                default: begin
                    state_d = ST_SETTLE;
                end
            endcase
        end

        // Window start: fresh threshold, cleared counters and accumulators.
        if (start) begin
            state_d      = ST_MEASURE;
            settle_cnt_d = '0;
            sample_cnt_d = '0;
            thr_d        = bus.threshold;
            trk_clr      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= ST_SETTLE;
            sample_cnt_q <= '0;
            settle_cnt_q <= '0;
            thr_q        <= '0;
            overload_q   <= 1'b0;
            ov_valid_q   <= 1'b0;
            peak_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            thr_q        <= thr_d;
            overload_q   <= overload_d;
            ov_valid_q   <= ov_valid_d;
            peak_out_q   <= peak_out_d;
        end
    end

    assign bus.overload       = overload_q;
    assign bus.overload_valid = ov_valid_q;
    assign bus.peak_out       = peak_out_q;
    assign bus.busy           = (state_q == ST_SETTLE);

endmodule
